// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants, index/word types and a popcount helper.
package mips_pkg;

    localparam int DATA           = 32;
    localparam int REGISTERWIDTH  = 5;
    localparam int REGISTERNUMBER = 32;
    localparam int NREAD_DEFAULT  = 2;
    localparam int NWRITE_DEFAULT = 2;

    typedef logic [REGISTERWIDTH-1:0] reg_idx_t;
    typedef logic [DATA-1:0]          word_t;

    // Number of set bits in a scoreboard vector, sized to hold REGISTERNUMBER.
    function automatic logic [REGISTERWIDTH:0] popcount(input logic [REGISTERNUMBER-1:0] v);
        logic [REGISTERWIDTH:0] cnt;
        cnt = '0;
        for (int i = 0; i < REGISTERNUMBER; i++) begin
            cnt = cnt + {{REGISTERWIDTH{1'b0}}, v[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/regfile_bypass.sv
// Same-cycle write forwarding for one read port; highest write port wins.
module regfile_bypass
    import mips_pkg::*;
#(
    parameter int NWRITE = NWRITE_DEFAULT
) (
    input  logic [NWRITE-1:0]                    we,
    input  logic [NWRITE-1:0][REGISTERWIDTH-1:0] wr_rd,
    input  logic [NWRITE-1:0][DATA-1:0]          wr_data,
    input  reg_idx_t                             rs,
    output logic                                 hit,
    output word_t                                fwd_data
);

    // Scan ports low to high so a later (higher priority) match overrides.
    always_comb begin
        hit      = 1'b0;
        fwd_data = '0;
        for (int k = 0; k < NWRITE; k++) begin
            if (we[k] && (wr_rd[k] == rs) && (rs != '0)) begin
                hit      = 1'b1;
                fwd_data = wr_data[k];
            end
        end
    end

endmodule

// File: rtl/scoreboard_regfile.sv
// Multi-ported register file with a busy-bit scoreboard for in-flight producers.
module scoreboard_regfile
    import mips_pkg::*;
#(
    parameter int NREAD  = NREAD_DEFAULT,
    parameter int NWRITE = NWRITE_DEFAULT
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 flush,
    input  logic                                 rsv_valid,
    input  reg_idx_t                             rsv_rd,
    output logic                                 rsv_ready,
    input  logic [NWRITE-1:0]                    we,
    input  logic [NWRITE-1:0][REGISTERWIDTH-1:0] wr_rd,
    input  logic [NWRITE-1:0][DATA-1:0]          wr_data,
    input  logic [NREAD-1:0][REGISTERWIDTH-1:0]  rs,
    output logic [NREAD-1:0][DATA-1:0]           rd_data,
    output logic [NREAD-1:0]                     rd_busy,
    output logic [REGISTERNUMBER-1:0]            busy_vec,
    output logic [REGISTERWIDTH:0]               busy_count
);

    word_t                     regs [REGISTERNUMBER];
    logic [REGISTERNUMBER-1:0] busy;
    logic [REGISTERNUMBER-1:0] busy_next;
    logic [NREAD-1:0]          fwd_hit;
    word_t                     fwd_data [NREAD];
    logic                      wr_hits_rsv;

    for (genvar i = 0; i < NREAD; i++) begin : g_read
        regfile_bypass #(.NWRITE(NWRITE)) u_bypass (
            .we       (we),
            .wr_rd    (wr_rd),
            .wr_data  (wr_data),
            .rs       (rs[i]),
            .hit      (fwd_hit[i]),
            .fwd_data (fwd_data[i])
        );
    end

    // Read ports: r0 and reset force zero, otherwise bypass beats storage.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int i = 0; i < NREAD; i++) begin
            if (reset && (rs[i] != '0)) begin
                rd_data[i] = fwd_hit[i] ? fwd_data[i] : regs[rs[i]];
                rd_busy[i] = busy[rs[i]] & ~fwd_hit[i];
            end
        end
    end

    // A reservation is accepted if the target is free or is being written now.
    always_comb begin
        wr_hits_rsv = 1'b0;
        for (int k = 0; k < NWRITE; k++) begin
            if (we[k] && (wr_rd[k] == rsv_rd)) begin
                wr_hits_rsv = 1'b1;
            end
        end
        rsv_ready = (rsv_rd == '0) | ~busy[rsv_rd] | wr_hits_rsv;
    end

    // Next scoreboard: writes release, flush clears all, a new reservation wins over a release.
    always_comb begin
        busy_next = busy;
        for (int k = 0; k < NWRITE; k++) begin
            if (we[k]) begin
                busy_next[wr_rd[k]] = 1'b0;
            end
        end
        if (flush) begin
            busy_next = '0;
        end else if (rsv_valid && rsv_ready && (rsv_rd != '0)) begin
            busy_next[rsv_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // Storage commit; later ports overwrite earlier ones on the same register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < REGISTERNUMBER; r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int k = 0; k < NWRITE; k++) begin
                if (we[k] && (wr_rd[k] != '0)) begin
                    regs[wr_rd[k]] <= wr_data[k];
                end
            end
        end
    end

    // Scoreboard state and its registered population count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy       <= '0;
            busy_count <= '0;
        end else begin
            busy       <= busy_next;
            busy_count <= popcount(busy_next);
        end
    end

    assign busy_vec = busy;

endmodule

// File: tb/tb_scoreboard_regfile.sv
// Directed bench for scoreboard_regfile with a behavioural reference model.
module tb_scoreboard_regfile;
    import mips_pkg::*;

    logic                clk;
    logic                reset;
    logic                flush;
    logic                rsv_valid;
    reg_idx_t            rsv_rd;
    logic                rsv_ready;
    logic [1:0]          we;
    logic [1:0][4:0]     wr_rd;
    logic [1:0][31:0]    wr_data;
    logic [1:0][4:0]     rs;
    logic [1:0][31:0]    rd_data;
    logic [1:0]          rd_busy;
    logic [31:0]         busy_vec;
    logic [5:0]          busy_count;

    int checks;
    int errors;

    word_t       mRegs [32];
    logic [31:0] mBusy;

    scoreboard_regfile #(.NREAD(2), .NWRITE(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .rsv_valid  (rsv_valid),
        .rsv_rd     (rsv_rd),
        .rsv_ready  (rsv_ready),
        .we         (we),
        .wr_rd      (wr_rd),
        .wr_data    (wr_data),
        .rs         (rs),
        .rd_data    (rd_data),
        .rd_busy    (rd_busy),
        .busy_vec   (busy_vec),
        .busy_count (busy_count)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] weV, input reg_idx_t a0, input word_t d0,
                                 input reg_idx_t a1, input word_t d1, input logic rv,
                                 input reg_idx_t rr, input logic fl, input reg_idx_t r0,
                                 input reg_idx_t r1);
        @(posedge clk);
        #2;
        we         = weV;
        wr_rd[0]   = a0;
        wr_data[0] = d0;
        wr_rd[1]   = a1;
        wr_data[1] = d1;
        rsv_valid  = rv;
        rsv_rd     = rr;
        flush      = fl;
        rs[0]      = r0;
        rs[1]      = r1;
        @(negedge clk);
    endtask

    function automatic logic anyWrite(input reg_idx_t idx);
        logic w;
        w = 1'b0;
        for (int k = 0; k < 2; k++) if (we[k] && wr_rd[k] == idx) w = 1'b1;
        return w;
    endfunction

    function automatic word_t expRead(input reg_idx_t idx);
        word_t v;
        if (idx == 0) return '0;
        v = mRegs[idx];
        for (int k = 0; k < 2; k++) if (we[k] && wr_rd[k] == idx) v = wr_data[k];
        return v;
    endfunction

    function automatic logic expReady();
        return (rsv_rd == 0) || !mBusy[rsv_rd] || anyWrite(rsv_rd);
    endfunction

    // Reference model: architectural registers and busy set updated per edge.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < 32; r++) mRegs[r] = '0;
            mBusy = '0;
        end else begin
            logic ready;
            ready = expReady();
            for (int k = 0; k < 2; k++) begin
                if (we[k] && wr_rd[k] != 0) begin
                    mRegs[wr_rd[k]] = wr_data[k];
                    mBusy[wr_rd[k]] = 1'b0;
                end
            end
            if (flush) mBusy = '0;
            else if (rsv_valid && ready && rsv_rd != 0) mBusy[rsv_rd] = 1'b1;
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) checkOutput("rst_rd_data", rd_data[i], 32'h0);
            checkOutput("rst_busy_vec", busy_vec, 32'h0);
            checkOutput("rst_busy_count", {26'h0, busy_count}, 32'h0);
        end else begin
            for (int i = 0; i < 2; i++) begin
                checkOutput("model_rd_data", rd_data[i], expRead(rs[i]));
                checkOutput("model_rd_busy", {31'h0, rd_busy[i]},
                            {31'h0, (rs[i] != 0) && mBusy[rs[i]] && !anyWrite(rs[i])});
            end
            checkOutput("model_rsv_ready", {31'h0, rsv_ready}, {31'h0, expReady()});
            checkOutput("model_busy_vec", busy_vec, mBusy);
            checkOutput("model_busy_count", {26'h0, busy_count}, $countones(mBusy));
        end
    end

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b0;
        flush     = 1'b0;
        rsv_valid = 1'b0;
        rsv_rd    = '0;
        we        = '0;
        wr_rd     = '0;
        wr_data   = '0;
        rs        = '0;

        // Reset held: a matching write must not leak onto rd_data.
        applyStimulus(2'b01, 5'd5, 32'h1234_5678, 5'd0, 32'h0, 1'b1, 5'd4, 1'b0, 5'd5, 5'd4);
        checkOutput("lit_reset_rd", rd_data[0], 32'h0);
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
        checkOutput("lit_reset_count", {26'h0, busy_count}, 32'h0);
        #1 reset = 1'b1;

        // Write r5, then read it back.
        applyStimulus(2'b01, 5'd5, 32'hDEAD_BEEF, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd5, 5'd0);
        checkOutput("lit_r5", rd_data[0], 32'hDEAD_BEEF);
        checkOutput("lit_r5_count", {26'h0, busy_count}, 32'h0);

        // Same-cycle bypass.
        applyStimulus(2'b01, 5'd7, 32'h11, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd7);
        checkOutput("lit_bypass", rd_data[1], 32'h11);
        checkOutput("lit_bypass_busy", {31'h0, rd_busy[1]}, 32'h0);

        // Write-port conflict on r3.
        applyStimulus(2'b11, 5'd3, 32'hAAAA, 5'd3, 32'h5555, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd3, 5'd7);
        checkOutput("lit_conflict", rd_data[0], 32'h5555);
        checkOutput("lit_r7", rd_data[1], 32'h11);

        // Scoreboard: reserve r9, rejected re-reservation, then release.
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b0, 5'd0, 5'd0);
        checkOutput("lit_rsv_ok", {31'h0, rsv_ready}, 32'h1);
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b0, 5'd9, 5'd0);
        checkOutput("lit_r9_busy", {31'h0, rd_busy[0]}, 32'h1);
        checkOutput("lit_rsv_reject", {31'h0, rsv_ready}, 32'h0);
        checkOutput("lit_count1", {26'h0, busy_count}, 32'h1);
        applyStimulus(2'b10, 5'd0, 32'h0, 5'd9, 32'h99, 1'b0, 5'd0, 1'b0, 5'd9, 5'd0);
        checkOutput("lit_r9_fwd", rd_data[0], 32'h99);
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd9, 5'd0);
        checkOutput("lit_count0", {26'h0, busy_count}, 32'h0);
        checkOutput("lit_r9_free", {31'h0, rd_busy[0]}, 32'h0);

        // Reservation beats release on r9.
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b0, 5'd0, 5'd0);
        applyStimulus(2'b01, 5'd9, 32'h1234, 5'd0, 32'h0, 1'b1, 5'd9, 1'b0, 5'd0, 5'd0);
        checkOutput("lit_rsv_wr_ready", {31'h0, rsv_ready}, 32'h1);
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd9, 5'd0);
        checkOutput("lit_busy9", busy_vec, 32'h0000_0200);
        checkOutput("lit_r9_new", rd_data[0], 32'h1234);

        // Reserve r1..r3, then flush with a write and an ignored reservation.
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd1, 1'b0, 5'd0, 5'd0);
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd2, 1'b0, 5'd0, 5'd0);
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b0, 5'd0, 5'd0);
        applyStimulus(2'b01, 5'd10, 32'h77, 5'd0, 32'h0, 1'b1, 5'd4, 1'b1, 5'd0, 5'd0);
        checkOutput("lit_count4", {26'h0, busy_count}, 32'h4);
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd10, 5'd0);
        checkOutput("lit_flush_vec", busy_vec, 32'h0);
        checkOutput("lit_flush_count", {26'h0, busy_count}, 32'h0);
        checkOutput("lit_flush_wr", rd_data[0], 32'h77);

        // Register 0 ignores writes and reservations.
        applyStimulus(2'b01, 5'd0, 32'hFF, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
        checkOutput("lit_r0_fwd", rd_data[0], 32'h0);
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b0, 5'd0, 5'd0);
        checkOutput("lit_r0_read", rd_data[0], 32'h0);
        checkOutput("lit_r0_ready", {31'h0, rsv_ready}, 32'h1);
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
        checkOutput("lit_r0_count", {26'h0, busy_count}, 32'h0);

        // Reset asserted mid-cycle discards pending write and reservation.
        applyStimulus(2'b01, 5'd12, 32'hCAFE, 5'd0, 32'h0, 1'b1, 5'd11, 1'b0, 5'd0, 5'd0);
        #1 reset = 1'b0;
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd12, 5'd5);
        #1 reset = 1'b1;
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd12, 5'd5);
        checkOutput("lit_mid_r12", rd_data[0], 32'h0);
        checkOutput("lit_mid_r5", rd_data[1], 32'h0);
        checkOutput("lit_mid_count", {26'h0, busy_count}, 32'h0);
        checkOutput("lit_mid_vec", busy_vec, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/scoreboard_regfile.md
SCOREBOARD_REGFILE -- requirements
Module: scoreboard_regfile

Interface
REQ-001 SHALL take parameter NREAD, default 2: number of read ports.
REQ-002 SHALL take parameter NWRITE, default 2: number of write ports; a higher index means higher priority.
REQ-003 SHALL take DATA, REGISTERWIDTH and REGISTERNUMBER from mips_pkg, defaults 32, 5 and 32: word width, index width and register count.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port flush, input, 1 bit: synchronous clear of all busy bits.
REQ-007 SHALL have port rsv_valid, input, 1 bit: request to reserve a destination register.
REQ-008 SHALL have port rsv_rd, input, REGISTERWIDTH bits: the register to reserve.
REQ-009 SHALL have port rsv_ready, output, 1 bit: the reservation is accepted this cycle.
REQ-010 SHALL have port we, input, NWRITE bits: per-port write enable.
REQ-011 SHALL have port wr_rd, input, NWRITE x REGISTERWIDTH bits: per-port write index.
REQ-012 SHALL have port wr_data, input, NWRITE x DATA bits: per-port write data.
REQ-013 SHALL have port rs, input, NREAD x REGISTERWIDTH bits: per-port read index.
REQ-014 SHALL have port rd_data, output, NREAD x DATA bits: per-port read data.
REQ-015 SHALL have port rd_busy, output, NREAD bits: operand not yet available.
REQ-016 SHALL have port busy_vec, output, REGISTERNUMBER bits: the scoreboard state.
REQ-017 SHALL have port busy_count, output, REGISTERWIDTH+1 bits: registered population count of busy_vec.

Function
REQ-018 SHALL hardwire register 0: it always reads 0, ignores writes, is never busy, and a reservation of it is always ready but has no effect.
REQ-019 SHALL make reads combinational, with zero-cycle latency from rs to rd_data.
REQ-020 SHALL forward the same-cycle write when we[k] is set and wr_rd[k]==rs[i]!=0; rd_data[i]=wr_data[k], and the highest matching k wins.
REQ-021 SHALL commit writes at the clock edge; when two ports write the same register in one cycle, the highest index wins.
REQ-022 SHALL drive rsv_ready = (rsv_rd==0) | ~busy[rsv_rd] | (a same-cycle write targets rsv_rd).
REQ-023 SHALL set busy[r] at the edge when rsv_valid & rsv_ready & r==rsv_rd & r!=0 & ~flush.
REQ-024 SHALL clear busy[r] at the edge when any write commits to r, unless REQ-023 sets it in the same cycle; a reservation beats a release, because it marks a new producer.
REQ-025 SHALL accept a write to a non-busy register: data is updated and busy stays 0.
REQ-026 SHALL, when flush=1, clear every busy bit at the edge, ignore the reservation, and still commit writes.
REQ-027 SHALL drive rd_busy[i] = busy[rs[i]] & ~(forward hit on port i); it is 0 for rs[i]==0.
REQ-028 SHALL update busy_count at the same edge as busy_vec, to equal the popcount of the new busy_vec; its range is 0..REGISTERNUMBER-1.
REQ-029 SHALL leave a rejected reservation (rsv_ready=0) with no state change; the requester holds rsv_valid and rsv_rd until ready.

Reset
REQ-030 SHALL, while reset=0, asynchronously clear all registers to 0, busy_vec to 0 and busy_count to 0.
REQ-031 SHALL, on reset assertion mid-operation, discard any in-flight reservation and same-edge write.
REQ-032 SHALL drive rd_data with 0 for every rs while reset is held.
REQ-033 SHALL resume normal operation at the first rising clk edge after reset deasserts.

Structure
REQ-034 SHALL place DATA, REGISTERWIDTH, REGISTERNUMBER and the default NREAD and NWRITE values in mips_pkg.
REQ-035 SHALL place a typedef reg_idx_t (REGISTERWIDTH bits) and word_t (DATA bits) in mips_pkg.
REQ-036 SHALL implement forwarding as one sub-module, regfile_bypass, instantiated once per read port; it is purely combinational, with a priority match over the NWRITE ports.
REQ-037 SHALL keep the storage array, the scoreboard and busy_count in the top module.

Verification
REQ-038 SHALL cover reset then write: reset low, then write r5=0xDEADBEEF on port 0; the next cycle rs[0]=5 gives 0xDEADBEEF and busy_count is 0.
REQ-039 SHALL cover same-cycle bypass: port 0 writes r7=0x11 and rs[1]=7 in the same cycle gives rd_data[1]=0x11 and rd_busy[1]=0.
REQ-040 SHALL cover the write-port conflict: ports 0 and 1 both write r3, with 0xAAAA and 0x5555; a later read of r3 gives 0x5555.
REQ-041 SHALL cover the scoreboard path: reserve r9, then the next cycle rs=9 gives rd_busy=1, rsv_ready for r9 is 0 and busy_count is 1; write r9, then busy clears and busy_count is 0.
REQ-042 SHALL cover reserve against release: r9 is busy, then a write to r9 and a reservation of r9 in the same cycle leave busy[9]=1 and r9 holding the new data.
REQ-043 SHALL cover flush and register 0: reserve r1, r2 and r3, then flush gives busy_vec=0 and busy_count=0; a write of 0xFF to r0 still reads 0, and a reservation of r0 leaves busy_count unchanged.
